// File: rtl/gsplat_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gsplat_pkg : shared DDR widths, arbiter state encoding and round-robin pick
// Revision   : 1.0
// ---------------------------------------------------------------------------
package gsplat_pkg;

  localparam int DDR_AW  = 29;
  localparam int DDR_DW  = 64;
  localparam int DDR_BEW = DDR_DW / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_CMD   = 2'd1,
    RD_DATA  = 2'd2,
    WR_BURST = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic rd;
    logic wr;
  } grant_t;

  // On a tie the client that was not served last wins.
  function automatic grant_t rr2(input logic req_rd, input logic req_wr, input logic last_was_wr);
    grant_t g;
    g.rd = req_rd && (!req_wr || last_was_wr);
    g.wr = req_wr && (!req_rd || !last_was_wr);
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gsplat_ddr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gsplat_ddr_arbiter : one-burst-at-a-time round-robin DDR3 Avalon arbiter
// Revision           : 1.0
// ---------------------------------------------------------------------------
module gsplat_ddr_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int DDR_AW  = 29,
  parameter int DDR_DW  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req,
  input  logic [DDR_AW-1:0]     rd_addr,
  input  logic [7:0]            rd_burstcnt,
  output logic                  rd_gnt,
  output logic [DDR_DW-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  wr_req,
  input  logic [DDR_AW-1:0]     wr_addr,
  input  logic [7:0]            wr_burstcnt,
  input  logic [DDR_DW-1:0]     wr_data,
  input  logic [DDR_DW/8-1:0]   wr_be,
  output logic                  wr_gnt,
  output logic                  wr_pop,
  output logic                  wr_last,
  input  logic                  ddram_busy,
  output logic [7:0]            ddram_burstcnt,
  output logic [DDR_AW-1:0]     ddram_addr,
  input  logic [DDR_DW-1:0]     ddram_dout,
  input  logic                  ddram_dout_ready,
  output logic                  ddram_rd,
  output logic [DDR_DW-1:0]     ddram_din,
  output logic [DDR_DW/8-1:0]   ddram_be,
  output logic                  ddram_we,
  output logic                  idle,
  output logic                  timeout_err
);
  import gsplat_pkg::*;

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] c_wd_max = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t     r_state;
  logic [7:0]     r_count;
  logic [WDW-1:0] r_wd;
  logic           r_last_was_wr;

  grant_t         w_grant;
  logic           w_rd_phase;
  logic           w_cmd_acc;
  logic           w_progress;
  logic           w_wd_fire;
  logic [7:0]     w_rd_bc;
  logic [7:0]     w_wr_bc;

  assign w_grant    = rr2(rd_req, wr_req, r_last_was_wr);
  assign w_rd_bc    = (rd_burstcnt == 8'd0) ? 8'd1 : rd_burstcnt;
  assign w_wr_bc    = (wr_burstcnt == 8'd0) ? 8'd1 : wr_burstcnt;
  assign w_rd_phase = (r_state == RD_CMD) || (r_state == RD_DATA);

  // Beats outside a read phase are strays and never reach the client.
  assign rd_valid   = ddram_dout_ready && w_rd_phase;
  assign rd_data    = ddram_dout;
  assign rd_last    = rd_valid && (r_count == 8'd1);
  assign wr_pop     = ddram_we && !ddram_busy && (r_state == WR_BURST);
  assign wr_last    = wr_pop && (r_count == 8'd1);
  assign ddram_din  = wr_data;
  assign ddram_be   = wr_be;
  assign idle       = (r_state == IDLE);

  assign w_cmd_acc  = (r_state == RD_CMD) && ddram_rd && !ddram_busy;
  assign w_progress = w_cmd_acc || wr_pop || rd_valid;
  assign w_wd_fire  = (TIMEOUT > 0) && !w_progress && (r_wd == c_wd_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_count        <= 8'd0;
      r_wd           <= '0;
      r_last_was_wr  <= 1'b1;
      ddram_rd       <= 1'b0;
      ddram_we       <= 1'b0;
      ddram_addr     <= '0;
      ddram_burstcnt <= 8'd0;
      rd_gnt         <= 1'b0;
      wr_gnt         <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      rd_gnt <= 1'b0;
      wr_gnt <= 1'b0;
      case (r_state)
        IDLE: begin
          r_wd <= '0;
          if (w_grant.rd) begin
            ddram_addr     <= rd_addr;
            ddram_burstcnt <= w_rd_bc;
            r_count        <= w_rd_bc;
            ddram_rd       <= 1'b1;
            rd_gnt         <= 1'b1;
            r_last_was_wr  <= 1'b0;
            r_state        <= RD_CMD;
          end else if (w_grant.wr) begin
            ddram_addr     <= wr_addr;
            ddram_burstcnt <= w_wr_bc;
            r_count        <= w_wr_bc;
            ddram_we       <= 1'b1;
            wr_gnt         <= 1'b1;
            r_last_was_wr  <= 1'b1;
            r_state        <= WR_BURST;
          end
        end
        default: begin
          if (w_wd_fire) begin
            timeout_err <= 1'b1;
            ddram_rd    <= 1'b0;
            ddram_we    <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_wd <= w_progress ? '0 : r_wd + WDW'(1);
            if (w_cmd_acc) begin
              ddram_rd <= 1'b0;
              r_state  <= RD_DATA;
            end
            // Last beat wins over command acceptance when both land together.
            if (rd_valid || wr_pop) begin
              r_count <= r_count - 8'd1;
              if (r_count == 8'd1) begin
                ddram_rd <= 1'b0;
                ddram_we <= 1'b0;
                r_state  <= IDLE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gsplat_ddr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gsplat_ddr_arbiter : directed self-checking bench for the DDR arbiter
// Revision              : 1.0
// ---------------------------------------------------------------------------
module tb_gsplat_ddr_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_req, wr_req;
  logic [28:0] rd_addr, wr_addr;
  logic [7:0]  rd_burstcnt, wr_burstcnt;
  logic        rd_gnt, rd_valid, rd_last;
  logic [63:0] rd_data;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        wr_gnt, wr_pop, wr_last;
  logic        ddram_busy;
  logic [7:0]  ddram_burstcnt;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;
  logic        ddram_rd;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic        ddram_we;
  logic        idle, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  gsplat_ddr_arbiter #(.TIMEOUT(16), .DDR_AW(29), .DDR_DW(64)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_burstcnt(rd_burstcnt),
    .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_burstcnt(wr_burstcnt),
    .wr_data(wr_data), .wr_be(wr_be), .wr_gnt(wr_gnt), .wr_pop(wr_pop), .wr_last(wr_last),
    .ddram_busy(ddram_busy), .ddram_burstcnt(ddram_burstcnt), .ddram_addr(ddram_addr),
    .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready), .ddram_rd(ddram_rd),
    .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_we(ddram_we),
    .idle(idle), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs;
    rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0;
    rd_burstcnt = 8'd0; wr_burstcnt = 8'd0;
    wr_data = '0; wr_be = '0;
    ddram_busy = 1'b0; ddram_dout = '0; ddram_dout_ready = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (ddram_rd !== 1'b0 || ddram_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_cmd: rd=%b we=%b, expected 0 0", ddram_rd, ddram_we);
    end
    n_checks++;
    if (ddram_addr !== 29'd0 || ddram_burstcnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_addr: addr=%h bc=%h, expected 0 0", ddram_addr, ddram_burstcnt);
    end
    n_checks++;
    if (rd_gnt !== 1'b0 || wr_gnt !== 1'b0) begin
      n_fail++; $display("FAIL reset_gnt: rd_gnt=%b wr_gnt=%b, expected 0 0", rd_gnt, wr_gnt);
    end
    n_checks++;
    if (timeout_err !== 1'b0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL reset_status: timeout_err=%b idle=%b, expected 0 1", timeout_err, idle);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_read;
    logic [63:0] exp_d;
    rd_req = 1'b1; rd_addr = 29'h0600000; rd_burstcnt = 8'd4;
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rd_gnt !== 1'b1 || ddram_rd !== 1'b1 || ddram_addr !== 29'h0600000 || ddram_burstcnt !== 8'd4 || idle !== 1'b0) begin
      n_fail++;
      $display("FAIL read_cmd: gnt=%b rd=%b addr=%h bc=%0d idle=%b, expected 1 1 0600000 4 0",
               rd_gnt, ddram_rd, ddram_addr, ddram_burstcnt, idle);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (ddram_rd !== 1'b0 || rd_gnt !== 1'b0) begin
      n_fail++; $display("FAIL read_cmd_drop: rd=%b gnt=%b, expected 0 0", ddram_rd, rd_gnt);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp_d = 64'hD00D_0000_0000_0000 | 64'(i * 3 + 1);
      ddram_dout_ready = 1'b1; ddram_dout = exp_d;
      @(negedge clk);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_d || rd_last !== (i == 3)) begin
        n_fail++;
        $display("FAIL read_beat%0d: valid=%b data=%h last=%b, expected 1 %h %b",
                 i, rd_valid, rd_data, rd_last, exp_d, (i == 3));
      end
    end
    @(posedge clk); #1;
    ddram_dout_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (idle !== 1'b1 || ddram_rd !== 1'b0) begin
      n_fail++; $display("FAIL read_done: idle=%b rd=%b, expected 1 0", idle, ddram_rd);
    end
  endtask

  task automatic test_write;
    int k;
    logic busy_t;
    logic [63:0] exp_w;
    logic [7:0]  exp_be;
    wr_req = 1'b1; wr_addr = 29'h0123456; wr_burstcnt = 8'd8;
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_gnt !== 1'b1 || ddram_we !== 1'b1 || ddram_addr !== 29'h0123456 || ddram_burstcnt !== 8'd8) begin
      n_fail++;
      $display("FAIL write_grant: gnt=%b we=%b addr=%h bc=%0d, expected 1 1 0123456 8",
               wr_gnt, ddram_we, ddram_addr, ddram_burstcnt);
    end
    k = 0; busy_t = 1'b1;
    for (int c = 0; c < 40 && k < 8; c++) begin
      exp_w  = {32'hCAFE_0000 | 32'(k), 32'h8765_4321 ^ 32'(k)};
      exp_be = 8'hFF ^ 8'(k);
      ddram_busy = busy_t; wr_data = exp_w; wr_be = exp_be;
      @(negedge clk);
      n_checks++;
      if (ddram_we !== 1'b1 || ddram_din !== exp_w || ddram_be !== exp_be || wr_pop !== !busy_t ||
          ddram_addr !== 29'h0123456 || wr_last !== (!busy_t && k == 7)) begin
        n_fail++;
        $display("FAIL write_beat%0d: we=%b din=%h be=%h pop=%b last=%b, expected 1 %h %h %b %b",
                 k, ddram_we, ddram_din, ddram_be, wr_pop, wr_last, exp_w, exp_be, !busy_t, (!busy_t && k == 7));
      end
      if (!busy_t) k++;
      busy_t = !busy_t;
      @(posedge clk); #1;
    end
    ddram_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (k != 8 || ddram_we !== 1'b0 || idle !== 1'b1 || wr_pop !== 1'b0) begin
      n_fail++;
      $display("FAIL write_done: pops=%0d we=%b idle=%b pop=%b, expected 8 0 1 0", k, ddram_we, idle, wr_pop);
    end
  endtask

  task automatic test_round_robin;
    string seq;
    int gn;
    logic prev_r, prev_w, ready_next;
    reset = 1'b1;
    idle_inputs();
    rd_req = 1'b1; wr_req = 1'b1;
    rd_addr = 29'h10; wr_addr = 29'h20;
    rd_burstcnt = 8'd1; wr_burstcnt = 8'd1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    seq = ""; gn = 0; prev_r = 1'b0; prev_w = 1'b0;
    for (int c = 0; c < 60 && gn < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if ((rd_gnt && prev_r) || (wr_gnt && prev_w) || (rd_gnt && wr_gnt)) begin
        n_fail++;
        $display("FAIL rr_pulse: rd_gnt=%b wr_gnt=%b prev=%b%b, expected single-cycle exclusive pulses",
                 rd_gnt, wr_gnt, prev_r, prev_w);
      end
      if (rd_gnt) begin seq = {seq, "R"}; gn++; end
      if (wr_gnt) begin seq = {seq, "W"}; gn++; end
      ready_next = rd_gnt; prev_r = rd_gnt; prev_w = wr_gnt;
      @(posedge clk); #1;
      ddram_dout_ready = ready_next;
    end
    rd_req = 1'b0; wr_req = 1'b0; ddram_dout_ready = 1'b0;
    n_checks++;
    if (seq != "RWRW") begin
      n_fail++; $display("FAIL rr_order: got '%s', expected 'RWRW'", seq);
    end
  endtask

  task automatic test_busy_hold;
    logic stable;
    do_reset();
    rd_req = 1'b1; rd_addr = 29'h1ABCDEF; rd_burstcnt = 8'd0; ddram_busy = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ddram_rd !== 1'b1 || ddram_addr !== 29'h1ABCDEF || ddram_burstcnt !== 8'd1) stable = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++; $display("FAIL busy_stable: stable=%b, expected 1 (rd high, addr and clamped bc held)", stable);
    end
    ddram_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ddram_rd !== 1'b1) begin
      n_fail++; $display("FAIL busy_release_pre: rd=%b, expected 1", ddram_rd);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (ddram_rd !== 1'b0 || idle !== 1'b0) begin
      n_fail++; $display("FAIL busy_rd_data: rd=%b idle=%b, expected 0 0", ddram_rd, idle);
    end
    ddram_dout_ready = 1'b1; ddram_dout = 64'h0123_4567_89AB_CDEF;
    #1;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_last !== 1'b1 || rd_data !== 64'h0123_4567_89AB_CDEF) begin
      n_fail++; $display("FAIL clamp_beat: valid=%b last=%b data=%h, expected 1 1 0123456789abcdef",
                         rd_valid, rd_last, rd_data);
    end
    @(posedge clk); #1;
    ddram_dout_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (idle !== 1'b1) begin
      n_fail++; $display("FAIL clamp_done: idle=%b, expected 1", idle);
    end
  endtask

  task automatic test_timeout;
    int hit;
    int pops, lasts;
    do_reset();
    rd_req = 1'b1; rd_addr = 29'h0000100; rd_burstcnt = 8'd4;
    @(posedge clk); #1;
    rd_req = 1'b0;
    hit = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (timeout_err === 1'b1) begin hit = i; break; end
    end
    n_checks++;
    if (hit != 17) begin
      n_fail++; $display("FAIL timeout_cycle: flag seen at cycle %0d after grant+1, expected 17", hit);
    end
    n_checks++;
    if (ddram_rd !== 1'b0 || idle !== 1'b1 || rd_last !== 1'b0) begin
      n_fail++; $display("FAIL timeout_abort: rd=%b idle=%b rd_last=%b, expected 0 1 0", ddram_rd, idle, rd_last);
    end
    wr_req = 1'b1; wr_addr = 29'h0000200; wr_burstcnt = 8'd2; wr_data = 64'h5A5A; wr_be = 8'h0F;
    @(posedge clk); #1;
    wr_req = 1'b0;
    pops = 0; lasts = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (wr_pop === 1'b1) pops++;
      if (wr_last === 1'b1) lasts++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (pops != 2 || lasts != 1 || idle !== 1'b1 || timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_recover: pops=%0d lasts=%0d idle=%b err=%b, expected 2 1 1 1",
                         pops, lasts, idle, timeout_err);
    end
  endtask

  task automatic test_reset_midwrite;
    do_reset();
    wr_req = 1'b1; wr_addr = 29'h00ABCDE; wr_burstcnt = 8'd8; wr_data = 64'h1111; wr_be = 8'hFF;
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (wr_pop !== 1'b1 || ddram_we !== 1'b1) begin
      n_fail++; $display("FAIL midwrite_beat3: pop=%b we=%b, expected 1 1", wr_pop, ddram_we);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (ddram_we !== 1'b0 || idle !== 1'b1 || wr_pop !== 1'b0 || ddram_addr !== 29'd0) begin
      n_fail++; $display("FAIL async_reset: we=%b idle=%b pop=%b addr=%h, expected 0 1 0 0",
                         ddram_we, idle, wr_pop, ddram_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    ddram_dout_ready = 1'b1; ddram_dout = 64'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if (rd_valid !== 1'b0 || timeout_err !== 1'b0 || ddram_we !== 1'b0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL stray_beat: valid=%b err=%b we=%b idle=%b, expected 0 0 0 1",
                         rd_valid, timeout_err, ddram_we, idle);
    end
    @(posedge clk); #1;
    ddram_dout_ready = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_busy_hold();
    test_timeout();
    test_reset_midwrite();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: bench still running at 200000, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
